cache_assoc: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate cache. It is the successor of the direct-mapped cache.
- Sits between the CPU load/store port and the line-wide memory port, using the same CPU and memory handshakes as the direct-mapped cache.
- Adds way count, per-set replacement (invalid-way-first, then round-robin), and a whole-cache flush (write back all dirty lines).

---
 rtl/cache_assoc.sv | 180 ++++++++++++++++++
 tb/tb_cache_assoc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc.sv
// cache_assoc: N-way set-associative write-back, write-allocate cache with round-robin replacement and whole-cache flush
module cache_assoc #(
  parameter int SIZE = 32768,
  parameter int LINE_SIZE = 256,
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int NUM_WAYS = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic [ADDR_SIZE-1:0] cache_addr,
  input  logic cache_access,
  input  logic cache_write,
  input  logic [1:0] cache_wr_size,
  input  logic [WORD_SIZE-1:0] cache_wr_data,
  output logic [WORD_SIZE-1:0] cache_rd_data,
  output logic cache_hit,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [LINE_SIZE-1:0] mem_wr_data,
  input  logic [LINE_SIZE-1:0] mem_rd_data,
  output logic mem_write,
  output logic mem_valid,
  input  logic mem_ready,
  input  logic flush_i,
  output logic flush_done_o,
  output logic busy_o
);
  localparam int NUM_SETS = SIZE / (LINE_SIZE * NUM_WAYS);
  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int WORD_BITS = $clog2(LINE_SIZE / WORD_SIZE);
  localparam int WOFF_BITS = $clog2(WORD_SIZE / 8);
  localparam int LOW_BITS = WORD_BITS + WOFF_BITS;
  localparam int TAG_BITS = ADDR_SIZE - INDEX_BITS - LOW_BITS;
  localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  typedef enum logic [2:0] {READY, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, FLUSH_SCAN, FLUSH_WB_REQ, FLUSH_WB_WAIT} state_t;
  state_t state;
  logic [NUM_WAYS-1:0] valid [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty [NUM_SETS];
  logic [TAG_BITS-1:0] tags [NUM_SETS][NUM_WAYS];
  logic [LINE_SIZE-1:0] lines [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] ptr [NUM_SETS];
  logic [INDEX_BITS-1:0] line_idx;
  logic [WAY_W-1:0] line_way, hit_way, vic_way, next_way;
  logic hit_any, line_dirty, last_way, last_line;
  logic [TAG_BITS-1:0] tag;
  logic [INDEX_BITS-1:0] idx;
  logic [WORD_BITS-1:0] word;
  logic [WOFF_BITS-1:0] woff;
  logic [WORD_SIZE-1:0] old_word, mask, rep, new_word;
  assign tag = cache_addr[ADDR_SIZE-1 -: TAG_BITS];
  assign idx = cache_addr[LOW_BITS +: INDEX_BITS];
  assign word = cache_addr[WOFF_BITS +: WORD_BITS];
  assign woff = cache_addr[WOFF_BITS-1:0];
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    vic_way = ptr[idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[idx][w]) vic_way = WAY_W'(w);
    end
  end
  assign old_word = lines[idx][hit_way][word*WORD_SIZE +: WORD_SIZE];
  assign mask = cache_wr_size == 2'd0 ? WORD_SIZE'(8'hFF) << {woff, 3'b000}
              : cache_wr_size == 2'd1 ? WORD_SIZE'(16'hFFFF) << {woff, 3'b000} : '1;
  assign rep = cache_wr_size == 2'd0 ? {(WORD_SIZE/8){cache_wr_data[7:0]}}
             : cache_wr_size == 2'd1 ? {(WORD_SIZE/16){cache_wr_data[15:0]}} : cache_wr_data;
  assign new_word = (old_word & ~mask) | (rep & mask);
  assign cache_rd_data = old_word;
  assign cache_hit = state == READY && hit_any;
  assign busy_o = state != READY;
  assign line_dirty = valid[line_idx][line_way] && dirty[line_idx][line_way];
  assign last_way = line_way == WAY_W'(NUM_WAYS - 1);
  assign last_line = last_way && line_idx == INDEX_BITS'(NUM_SETS - 1);
  assign next_way = last_way ? '0 : line_way + 1'b1;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= READY;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wr_data <= '0;
      flush_done_o <= 1'b0;
      line_idx <= '0;
      line_way <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        ptr[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          tags[s][w] <= '0;
          lines[s][w] <= '0;
        end
      end
    end else begin
      flush_done_o <= 1'b0;
      case (state)
        READY:
          if (cache_access && hit_any) begin
            if (cache_write) begin
              lines[idx][hit_way][word*WORD_SIZE +: WORD_SIZE] <= new_word;
              dirty[idx][hit_way] <= 1'b1;
            end
          end else if (cache_access && mem_ready) begin
            line_idx <= idx;
            line_way <= vic_way;
            mem_valid <= 1'b1;
            if (valid[idx][vic_way] && dirty[idx][vic_way]) begin
              state <= WB_REQ;
              mem_write <= 1'b1;
              mem_addr <= {tags[idx][vic_way], idx, {LOW_BITS{1'b0}}};
              mem_wr_data <= lines[idx][vic_way];
            end else begin
              state <= FILL_REQ;
              mem_write <= 1'b0;
              mem_addr <= {tag, idx, {LOW_BITS{1'b0}}};
            end
          end else if (!cache_access && flush_i && !flush_done_o) begin
            state <= FLUSH_SCAN;
            line_idx <= '0;
            line_way <= '0;
          end
        WB_REQ, FILL_REQ, FLUSH_WB_REQ:
          if (!mem_ready) begin
            mem_valid <= 1'b0;
            state <= state == WB_REQ ? WB_WAIT : state == FILL_REQ ? FILL_WAIT : FLUSH_WB_WAIT;
          end
        WB_WAIT:
          if (mem_ready) begin
            dirty[line_idx][line_way] <= 1'b0;
            state <= FILL_REQ;
            mem_valid <= 1'b1;
            mem_write <= 1'b0;
            mem_addr <= {tag, line_idx, {LOW_BITS{1'b0}}};
          end
        FILL_WAIT:
          if (mem_ready) begin
            lines[line_idx][line_way] <= mem_rd_data;
            tags[line_idx][line_way] <= tag;
            valid[line_idx][line_way] <= 1'b1;
            dirty[line_idx][line_way] <= 1'b0;
            ptr[line_idx] <= next_way;
            state <= READY;
          end
        FLUSH_SCAN:
          if (line_dirty) begin
            if (mem_ready) begin
              state <= FLUSH_WB_REQ;
              mem_valid <= 1'b1;
              mem_write <= 1'b1;
              mem_addr <= {tags[line_idx][line_way], line_idx, {LOW_BITS{1'b0}}};
              mem_wr_data <= lines[line_idx][line_way];
            end
          end else if (last_line) begin
            state <= READY;
            flush_done_o <= 1'b1;
          end else begin
            line_way <= next_way;
            if (last_way) line_idx <= line_idx + 1'b1;
          end
        FLUSH_WB_WAIT:
          if (mem_ready) begin
            dirty[line_idx][line_way] <= 1'b0;
            if (last_line) begin
              state <= READY;
              flush_done_o <= 1'b1;
            end else begin
              state <= FLUSH_SCAN;
              line_way <= next_way;
              if (last_way) line_idx <= line_idx + 1'b1;
            end
          end
        default: state <= READY;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc: directed scenario tests for cache_assoc against a line-wide memory responder
module tb_cache_assoc;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [31:0] cache_addr = '0;
  logic access = 1'b0, write = 1'b0;
  logic [1:0] wr_size = 2'd2;
  logic [31:0] wr_data = '0, rd_data;
  logic hit;
  logic [31:0] mem_addr;
  logic [255:0] mem_wr_data, mem_rd_data;
  logic mem_write, mem_valid, mem_ready;
  logic flush_i = 1'b0, flush_done_o, busy_o;
  int errors = 0, checks = 0;
  typedef struct {logic [31:0] addr; logic wr; logic [255:0] data;} txn_t;
  txn_t log_q[$];
  logic [255:0] model [logic [31:0]];

  cache_assoc dut (
    .clk_i(clk), .reset_i(reset_i),
    .cache_addr(cache_addr), .cache_access(access), .cache_write(write),
    .cache_wr_size(wr_size), .cache_wr_data(wr_data), .cache_rd_data(rd_data), .cache_hit(hit),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_write(mem_write), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (model.exists(a)) return model[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 | a | i;
    return l;
  endfunction

  // memory: accept a request, drop ready for two cycles, then answer
  initial begin
    mem_ready = 1'b1;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (mem_valid && mem_ready) begin
        log_q.push_back('{mem_addr, mem_write, mem_wr_data});
        mem_ready = 1'b0;
        if (mem_write) model[mem_addr] = mem_wr_data;
        else mem_rd_data = line_of(mem_addr);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
      end
    end
  end

  task automatic cpu(input logic [31:0] a, input logic w, input logic [1:0] sz, input logic [31:0] d,
                     output logic fh, output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    cache_addr = a; access = 1'b1; write = w; wr_size = sz; wr_data = d;
    #1 fh = hit;
    while (!hit && n < 200) begin
      @(negedge clk);
      #1 n++;
    end
    if (!hit) begin
      errors++;
      $display("FAIL cpu_timeout addr=%h: no hit after %0d cycles", a, n);
    end
    checks++;
    rd = rd_data;
    @(posedge clk);
    #1 access = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl: valid=%b write=%b expected 0 0", mem_valid, mem_write); end
    checks++; if (mem_addr !== 32'h0 || mem_wr_data !== 256'h0) begin errors++; $display("FAIL reset_mem_data: addr=%h data=%h expected 0", mem_addr, mem_wr_data); end
    checks++; if (busy_o !== 1'b0 || flush_done_o !== 1'b0) begin errors++; $display("FAIL reset_status: busy=%b done=%b expected 0 0", busy_o, flush_done_o); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
  endtask

  task automatic test_fill;
    logic fh; logic [31:0] rd;
    cpu(32'h0, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (fh !== 1'b0) begin errors++; $display("FAIL fill_first_hit: got %b expected 0", fh); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fill_rd: got %h expected deadbeef", rd); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL fill_txn_count: got %0d expected 1", log_q.size()); end
    else begin
      checks++; if (log_q[0].wr !== 1'b0 || log_q[0].addr !== 32'h0) begin errors++; $display("FAIL fill_req: wr=%b addr=%h expected 0 00000000", log_q[0].wr, log_q[0].addr); end
    end
  endtask

  task automatic test_two_way_reuse;
    logic fh; logic [31:0] rd; int n0;
    cpu(32'h800, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (fh !== 1'b0 || rd !== 32'hA000_0800) begin errors++; $display("FAIL reuse_fill800: hit=%b rd=%h expected 0 a0000800", fh, rd); end
    n0 = log_q.size();
    cpu(32'h0, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (fh !== 1'b1 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL reuse_hit0: hit=%b rd=%h expected 1 deadbeef", fh, rd); end
    cpu(32'h804, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (fh !== 1'b1 || rd !== 32'hA000_0801) begin errors++; $display("FAIL reuse_hit804: hit=%b rd=%h expected 1 a0000801", fh, rd); end
    checks++; if (log_q.size() != n0) begin errors++; $display("FAIL reuse_traffic: got %0d txns expected %0d", log_q.size(), n0); end
  endtask

  task automatic test_eviction;
    logic fh; logic [31:0] rd; int n0;
    cpu(32'h0, 1'b1, 2'd2, 32'h11223344, fh, rd);
    n0 = log_q.size();
    cpu(32'h1000, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (fh !== 1'b0 || rd !== 32'hA000_1000) begin errors++; $display("FAIL evict_rd: hit=%b rd=%h expected 0 a0001000", fh, rd); end
    checks++; if (log_q.size() != n0 + 2) begin errors++; $display("FAIL evict_txn_count: got %0d expected %0d", log_q.size(), n0 + 2); end
    else begin
      checks++; if (log_q[n0].wr !== 1'b1 || log_q[n0].addr !== 32'h0 || log_q[n0].data[31:0] !== 32'h11223344)
        begin errors++; $display("FAIL evict_wb: wr=%b addr=%h w0=%h expected 1 00000000 11223344", log_q[n0].wr, log_q[n0].addr, log_q[n0].data[31:0]); end
      checks++; if (log_q[n0+1].wr !== 1'b0 || log_q[n0+1].addr !== 32'h1000)
        begin errors++; $display("FAIL evict_fill: wr=%b addr=%h expected 0 00001000", log_q[n0+1].wr, log_q[n0+1].addr); end
    end
    cpu(32'h800, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (fh !== 1'b1) begin errors++; $display("FAIL evict_keep800: hit=%b expected 1", fh); end
  endtask

  task automatic test_partial_writes;
    logic fh; logic [31:0] rd;
    cpu(32'h4, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL partial_init: got %h expected 00000000", rd); end
    cpu(32'h5, 1'b1, 2'd0, 32'h000000AB, fh, rd);
    cpu(32'h4, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (rd !== 32'h0000AB00) begin errors++; $display("FAIL partial_byte: got %h expected 0000ab00", rd); end
    cpu(32'h6, 1'b1, 2'd1, 32'h0000CDEF, fh, rd);
    cpu(32'h4, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (rd !== 32'hCDEFAB00) begin errors++; $display("FAIL partial_half: got %h expected cdefab00", rd); end
    cpu(32'h0, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL partial_neighbor: got %h expected 11223344", rd); end
  endtask

  task automatic test_flush;
    logic fh; logic [31:0] rd; int n0, n, pulse;
    cpu(32'h1000, 1'b1, 2'd2, 32'h55551000, fh, rd);
    cpu(32'h20, 1'b1, 2'd2, 32'h55550020, fh, rd);
    for (int pass = 0; pass < 2; pass++) begin
      n0 = log_q.size();
      n = 0;
      @(negedge clk);
      flush_i = 1'b1;
      while (!flush_done_o && n < 2000) begin @(negedge clk); n++; end
      flush_i = 1'b0;
      checks++; if (flush_done_o !== 1'b1) begin errors++; $display("FAIL flush_done_timeout pass %0d: no done after %0d cycles", pass, n); end
      pulse = 0;
      repeat (3) begin @(negedge clk); if (flush_done_o) pulse++; end
      checks++; if (pulse != 0 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_pulse pass %0d: extra done cycles=%0d busy=%b expected 0 0", pass, pulse, busy_o); end
      checks++; if (log_q.size() != n0 + (pass == 0 ? 3 : 0)) begin errors++; $display("FAIL flush_wb_count pass %0d: got %0d expected %0d", pass, log_q.size() - n0, pass == 0 ? 3 : 0); end
      else if (pass == 0) begin
        checks++; if (log_q[n0].addr !== 32'h1000 || log_q[n0+1].addr !== 32'h0 || log_q[n0+2].addr !== 32'h20)
          begin errors++; $display("FAIL flush_order: got %h %h %h expected 00001000 00000000 00000020", log_q[n0].addr, log_q[n0+1].addr, log_q[n0+2].addr); end
        checks++; if (!log_q[n0].wr || !log_q[n0+1].wr || !log_q[n0+2].wr) begin errors++; $display("FAIL flush_wr: got %b%b%b expected 111", log_q[n0].wr, log_q[n0+1].wr, log_q[n0+2].wr); end
        checks++; if (log_q[n0].data[31:0] !== 32'h55551000 || log_q[n0+1].data[63:32] !== 32'hCDEFAB00 || log_q[n0+2].data[31:0] !== 32'h55550020)
          begin errors++; $display("FAIL flush_data: got %h %h %h expected 55551000 cdefab00 55550020", log_q[n0].data[31:0], log_q[n0+1].data[63:32], log_q[n0+2].data[31:0]); end
        n0 = log_q.size();
        cpu(32'h1000, 1'b0, 2'd2, 32'h0, fh, rd);
        checks++; if (fh !== 1'b1 || rd !== 32'h55551000) begin errors++; $display("FAIL flush_keep1000: hit=%b rd=%h expected 1 55551000", fh, rd); end
        cpu(32'h4, 1'b0, 2'd2, 32'h0, fh, rd);
        checks++; if (fh !== 1'b1 || rd !== 32'hCDEFAB00) begin errors++; $display("FAIL flush_keep0: hit=%b rd=%h expected 1 cdefab00", fh, rd); end
        cpu(32'h20, 1'b0, 2'd2, 32'h0, fh, rd);
        checks++; if (fh !== 1'b1 || log_q.size() != n0) begin errors++; $display("FAIL flush_keep20: hit=%b txns=%0d expected 1 0", fh, log_q.size() - n0); end
      end
    end
  endtask

  task automatic test_reset_mid_fill;
    logic fh; logic [31:0] rd; int n0, k;
    n0 = log_q.size();
    k = 0;
    @(negedge clk);
    cache_addr = 32'h2000; access = 1'b1; write = 1'b0;
    while (log_q.size() == n0 && k < 100) begin @(negedge clk); #2 k++; end
    checks++; if (log_q.size() == n0) begin errors++; $display("FAIL rst_fill_req: no fill request after %0d cycles", k); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_in_wait: busy=%b expected 1", busy_o); end
    reset_i = 1'b1; access = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL rst_abort: busy=%b valid=%b expected 0 0", busy_o, mem_valid); end
    cpu(32'h2000, 1'b0, 2'd2, 32'h0, fh, rd);
    checks++; if (fh !== 1'b0) begin errors++; $display("FAIL rst_line_dropped: first hit=%b expected 0", fh); end
    checks++; if (rd !== 32'hA000_2000) begin errors++; $display("FAIL rst_refill: rd=%h expected a0002000", rd); end
  endtask

  initial begin
    model[32'h0] = {224'h0, 32'hDEADBEEF};
    test_reset;
    test_fill;
    test_two_way_reuse;
    test_eviction;
    test_partial_writes;
    test_flush;
    test_reset_mid_fill;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
